// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch path: state encoding and default datapath width.
package cpu_pkg;

   localparam int ADDR_W_DEFAULT = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_LOAD = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// WAIT-state cycle counter; expired flags the last cycle the fetch may still wait.
module fetch_timeout_ctr #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic clr,
   input  logic load,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT) + 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign expired = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: issues one memory read per accepted start and loads ir.
// state  | meaning
// S_IDLE | waiting for start; ir/ir_valid hold the last result
// S_REQ  | read strobe issued, mem_ready not yet trusted
// S_WAIT | strobe held, waiting for data or timeout
// S_LOAD | ir loaded, inc_pc pulsed
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int ADDR_W  = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic              flush,
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] ir,
   output logic              ir_valid,
   output logic              inc_pc,
   output logic              busy,
   output logic              fetch_err
);

   fetch_state_t state;
   logic         tmo_load;
   logic         tmo_en;
   logic         tmo_expired;

   assign tmo_load = (state == S_REQ);
   assign tmo_en   = (state == S_WAIT) && !mem_ready && !flush;

   fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk     (clk),
      .clr     (clr),
      .load    (tmo_load),
      .enable  (tmo_en),
      .expired (tmo_expired)
   );

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state     <= S_IDLE;
         mem_addr  <= '0;
         mem_rd    <= 1'b0;
         ir        <= '0;
         ir_valid  <= 1'b0;
         inc_pc    <= 1'b0;
         busy      <= 1'b0;
         fetch_err <= 1'b0;
      end else begin
         inc_pc    <= 1'b0;
         fetch_err <= 1'b0;
         // flush outranks data and timeout in every state
         if (flush) begin
            state    <= S_IDLE;
            mem_rd   <= 1'b0;
            ir_valid <= 1'b0;
            busy     <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     mem_addr <= pc;
                     ir_valid <= 1'b0;
                     mem_rd   <= 1'b1;
                     busy     <= 1'b1;
                     state    <= S_REQ;
                  end
               end
               S_REQ: begin
                  state <= S_WAIT;
               end
               S_WAIT: begin
                  if (mem_ready) begin
                     ir       <= mem_rdata;
                     ir_valid <= 1'b1;
                     inc_pc   <= 1'b1;
                     mem_rd   <= 1'b0;
                     state    <= S_LOAD;
                  end else if (tmo_expired) begin
                     fetch_err <= 1'b1;
                     mem_rd    <= 1'b0;
                     ir_valid  <= 1'b0;
                     busy      <= 1'b0;
                     state     <= S_IDLE;
                  end
               end
               S_LOAD: begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
               default: begin
                  mem_rd <= 1'b0;
                  busy   <= 1'b0;
                  state  <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with TIMEOUT=4; expected values are hand-derived.
module tb_instr_fetch;

   logic        clk;
   logic        clr;
   logic        start;
   logic        flush;
   logic [31:0] pc;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic        mem_rd;
   logic [31:0] ir;
   logic        ir_valid;
   logic        inc_pc;
   logic        busy;
   logic        fetch_err;

   int n_cmp = 0;
   int n_bad = 0;
   int inc_cnt = 0;
   int err_cnt = 0;
   int inc_base;
   int err_base;

   instr_fetch #(.TIMEOUT(4), .ADDR_W(32)) dut (
      .clk       (clk),
      .clr       (clr),
      .start     (start),
      .flush     (flush),
      .pc        (pc),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .ir        (ir),
      .ir_valid  (ir_valid),
      .inc_pc    (inc_pc),
      .busy      (busy),
      .fetch_err (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (inc_pc === 1'b1) inc_cnt <= inc_cnt + 1;
      if (fetch_err === 1'b1) err_cnt <= err_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr = 1'b0; start = 1'b0; flush = 1'b0; pc = '0;
      mem_rdata = 32'hFFFF_FFFF; mem_ready = 1'b0;
      #3;
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_rd", {31'b0, mem_rd}, 32'h0);
      chk("rst_ir", ir, 32'h0);
      chk("rst_ir_valid", {31'b0, ir_valid}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      #9 clr = 1'b1;

      // basic fetch, data on second WAIT cycle
      pc = 32'h10; start = 1'b1;
      tick();                                   // -> REQ
      start = 1'b0;
      chk("f1_busy", {31'b0, busy}, 32'h1);
      chk("f1_mem_rd_req", {31'b0, mem_rd}, 32'h1);
      chk("f1_mem_addr", mem_addr, 32'h10);
      mem_ready = 1'b1;                         // ignored in REQ
      tick();                                   // -> WAIT (ctr 0)
      mem_ready = 1'b0;
      chk("f1_mem_rd_wait", {31'b0, mem_rd}, 32'h1);
      chk("f1_no_early_load", {31'b0, inc_pc}, 32'h0);
      tick();                                   // WAIT (ctr 1)
      mem_ready = 1'b1; mem_rdata = 32'hA5A5_0001;
      tick();                                   // -> LOAD
      mem_ready = 1'b0; mem_rdata = 32'h5555_5555;
      chk("f1_inc_pc", {31'b0, inc_pc}, 32'h1);
      chk("f1_ir", ir, 32'hA5A5_0001);
      chk("f1_ir_valid", {31'b0, ir_valid}, 32'h1);
      chk("f1_mem_rd_off", {31'b0, mem_rd}, 32'h0);
      tick();                                   // -> IDLE
      chk("f1_inc_once", {31'b0, inc_pc}, 32'h0);
      chk("f1_idle_busy", {31'b0, busy}, 32'h0);
      chk("f1_ir_valid_hold", {31'b0, ir_valid}, 32'h1);
      chk("f1_inc_cnt", inc_cnt, 32'd1);

      // timeout: fetch_err on 5th edge after the accepting edge
      inc_base = inc_cnt; err_base = err_cnt;
      start = 1'b1;
      tick();                                   // e0 -> REQ
      start = 1'b0;
      chk("to_ir_valid_clr", {31'b0, ir_valid}, 32'h0);
      for (int i = 1; i <= 4; i++) tick();      // e1..e4: WAIT ctr 0..3
      chk("to_not_yet", {31'b0, fetch_err}, 32'h0);
      chk("to_busy_wait", {31'b0, busy}, 32'h1);
      tick();                                   // e5
      chk("to_fetch_err", {31'b0, fetch_err}, 32'h1);
      chk("to_busy_off", {31'b0, busy}, 32'h0);
      chk("to_mem_rd_off", {31'b0, mem_rd}, 32'h0);
      chk("to_ir_kept", ir, 32'hA5A5_0001);
      tick();
      chk("to_err_pulse", {31'b0, fetch_err}, 32'h0);
      chk("to_err_cnt", err_cnt - err_base, 32'd1);
      chk("to_no_inc", inc_cnt - inc_base, 32'd0);

      // data arriving on the terminal-count cycle wins
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 4; i++) tick();
      mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
      tick();
      mem_ready = 1'b0;
      chk("tc_inc_pc", {31'b0, inc_pc}, 32'h1);
      chk("tc_no_err", {31'b0, fetch_err}, 32'h0);
      chk("tc_ir", ir, 32'h1234_5678);
      tick();

      // flush + mem_ready together in WAIT
      inc_base = inc_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();                                   // WAIT
      flush = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0000_DEAD;
      tick();
      flush = 1'b0; mem_ready = 1'b0;
      chk("fl_busy", {31'b0, busy}, 32'h0);
      chk("fl_ir_kept", ir, 32'h1234_5678);
      chk("fl_ir_valid", {31'b0, ir_valid}, 32'h0);
      chk("fl_mem_rd", {31'b0, mem_rd}, 32'h0);
      tick();
      chk("fl_no_inc", inc_cnt - inc_base, 32'd0);

      // flush with start in IDLE: start ignored
      start = 1'b1; flush = 1'b1;
      tick();
      start = 1'b0; flush = 1'b0;
      chk("fs_busy", {31'b0, busy}, 32'h0);
      chk("fs_mem_rd", {31'b0, mem_rd}, 32'h0);

      // async reset in WAIT, then a normal fetch
      inc_base = inc_cnt; err_base = err_cnt;
      pc = 32'h44; start = 1'b1;
      tick();
      start = 1'b0;
      tick();                                   // WAIT
      #2 clr = 1'b0;
      #1;
      chk("ar_busy", {31'b0, busy}, 32'h0);
      chk("ar_mem_rd", {31'b0, mem_rd}, 32'h0);
      chk("ar_mem_addr", mem_addr, 32'h0);
      chk("ar_ir", ir, 32'h0);
      #1 clr = 1'b1;
      pc = 32'h50; start = 1'b1;
      tick();
      start = 1'b0;
      chk("ar_restart_busy", {31'b0, busy}, 32'h1);
      chk("ar_restart_addr", mem_addr, 32'h50);
      tick();
      mem_ready = 1'b1; mem_rdata = 32'hCAFE_0050;
      tick();
      mem_ready = 1'b0;
      chk("ar_ir_load", ir, 32'hCAFE_0050);
      tick();
      chk("ar_pulses_inc", inc_cnt - inc_base, 32'd1);
      chk("ar_pulses_err", err_cnt - err_base, 32'd0);

      // start held with mem_ready tied high: one LOAD every 4 cycles
      pc = 32'h30; start = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0000_0030;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("b2b_inc_%0d", i), {31'b0, inc_pc}, (i % 4 == 2) ? 32'h1 : 32'h0);
      end
      start = 1'b0;
      tick();                                   // WAIT -> LOAD
      mem_ready = 1'b0;
      tick();

      // pc change during WAIT, plus start while busy
      pc = 32'h20; start = 1'b1;
      tick();
      start = 1'b0;
      tick();                                   // WAIT
      pc = 32'h21; start = 1'b1;
      tick();
      start = 1'b0;
      chk("pc_hold_wait", mem_addr, 32'h20);
      mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
      tick();
      mem_ready = 1'b0;
      chk("pc_hold_load", mem_addr, 32'h20);
      chk("pc_ir", ir, 32'h0BAD_F00D);
      tick();
      tick();
      chk("busy_start_not_queued", {31'b0, busy}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles spent in WAIT before a fetch aborts.
REQ-002 Parameter ADDR_W, default 32: address and instruction width.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 clr  input  1  asynchronous, active-low reset: clr=0 resets immediately, independent of clk.
REQ-005 start  input  1  control unit requests an instruction fetch; sampled only in IDLE.
REQ-006 flush  input  1  abort any fetch in progress (branch/jump taken).
REQ-007 pc  input  ADDR_W  current PC register value (word address).
REQ-008 mem_rdata  input  ADDR_W  memory read data.
REQ-009 mem_ready  input  1  memory read data valid this cycle.
REQ-010 mem_addr  output  ADDR_W  registered read address.
REQ-011 mem_rd  output  1  memory read strobe.
REQ-012 ir  output  ADDR_W  instruction register.
REQ-013 ir_valid  output  1  ir holds a completed, unflushed fetch.
REQ-014 inc_pc  output  1  one-cycle pulse driving the PC register's incPC input.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 fetch_err  output  1  one-cycle pulse on timeout.

Function
REQ-017 States: IDLE, REQ, WAIT, LOAD; fully registered Moore outputs except where stated.
REQ-018 IDLE: on start=1 and flush=0, latch pc into mem_addr, clear ir_valid, go to REQ.
REQ-019 REQ: mem_rd=1 for exactly one cycle; go to WAIT; load timeout counter with 0.
REQ-020 WAIT: mem_rd=1 held; on mem_ready=1 capture mem_rdata into ir, go to LOAD; otherwise increment counter.
REQ-021 mem_ready in REQ is ignored; memory response latency is therefore at least 2 cycles from start.
REQ-022 LOAD: inc_pc=1 and ir_valid set for one cycle, then IDLE; ir_valid stays high until the next accepted start, flush, or reset.
REQ-023 Minimum start-to-inc_pc latency is 3 cycles (start edge -> REQ -> WAIT with mem_ready -> LOAD).
REQ-024 Timeout: when counter reaches TIMEOUT-1 in WAIT without mem_ready, pulse fetch_err, drop mem_rd, go to IDLE; ir unchanged, ir_valid=0, no inc_pc.
REQ-025 mem_ready on the same cycle the counter hits TIMEOUT-1 counts as success (data wins over timeout).
REQ-026 flush in any state: next state IDLE, mem_rd=0, ir_valid=0, no inc_pc, no fetch_err; flush wins over mem_ready and timeout.
REQ-027 flush with start in IDLE: start ignored.
REQ-028 start while busy=1 is ignored and not queued.
REQ-029 pc changes after REQ-018 latch do not affect mem_addr of the fetch in progress.
REQ-030 mem_rdata is sampled only on the WAIT cycle with mem_ready=1.
REQ-031 Counter width is clog2(TIMEOUT)+1; no wrap-around can occur in normal operation.

Reset
REQ-032 clr=0 forces state IDLE, mem_addr=0, mem_rd=0, ir=0, ir_valid=0, inc_pc=0, busy=0, fetch_err=0, counter=0 asynchronously.
REQ-033 Reset asserted mid-fetch abandons it; no inc_pc or fetch_err pulse is emitted on release.
REQ-034 First start is accepted on the first rising clk edge with clr=1.

Structure
REQ-035 State encoding and ADDR_W default live in shared package cpu_pkg.
REQ-036 Timeout counter is a separate sub-module fetch_timeout_ctr (load, enable, expired output).
REQ-037 No combinational path from mem_rdata to any output.

Verification
REQ-038 pc=0x10, start, mem_ready on 2nd cycle of WAIT with mem_rdata=0xA5A5_0001 -> mem_addr=0x10, ir=0xA5A5_0001, one inc_pc pulse, ir_valid=1.
REQ-039 TIMEOUT=4, start, mem_ready never -> fetch_err pulse 5 cycles after start, no inc_pc, ir unchanged, busy=0 after.
REQ-040 flush and mem_ready asserted together in WAIT -> IDLE, ir unchanged, ir_valid=0, no inc_pc.
REQ-041 clr=0 in WAIT between clock edges -> all outputs 0 immediately; after release, start fetches normally.
REQ-042 start held high for 10 cycles with mem_ready tied 1 -> back-to-back fetches, exactly one inc_pc per fetch, each 4 cycles apart.
REQ-043 pc changed from 0x20 to 0x21 during WAIT -> mem_addr stays 0x20 until fetch completes.
